uart_tx_engine: RTL and testbench

//   UART transmit engine; TX counterpart of the UART receive engine.

---
 rtl/uart_tx_engine.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
//
// Purpose:
//   UART transmit engine, the TX counterpart of the UART receive engine. It sits
//   between the CSR/FIFO layer and the uart_tx pin. Each valid/ready handshake
//   serialises one byte as:
//     start bit (0), 5..8 data bits LSB first, optional parity bit,
//     1 / 1.5 / 2 stop bits (1).
//   It uses the same config fields as the RX side (clk_div, check_en,
//   check_type, data_bit, stop_bit). All frame settings are captured at the
//   accept edge, so CSR writes made during a frame only affect later frames.
//
// Parameters:
//   CLK_DIV_MIN    smallest bit period in clk cycles; a smaller clk_div is
//                  raised to this value
//
// Optional feature (compile-time macro):
//   UART_TX_CTS_EN defined   -> cts_n port present, synchronised by two flops;
//                               a new byte is accepted only while CTS is
//                               asserted. A frame already in flight always
//                               completes.
//   UART_TX_CTS_EN undefined -> no cts_n port; ready whenever idle.
//
// Ports:
//   clk            in   1   system clock
//   rst_n          in   1   asynchronous, active-low reset
//   clk_div        in   32  clk cycles per bit
//   check_en       in   1   1 = parity bit present
//   check_type     in   2   00 even, 01 odd, 10 mark (1), 11 space (0)
//   data_bit       in   2   00:5, 01:6, 10:7, 11:8 data bits
//   stop_bit       in   2   00:1, 01:1.5, 10:2, 11:1 stop bits
//   tx_data        in   8   byte to send; bits above the data length ignored
//   tx_valid       in   1   tx_data valid
//   tx_ready       out  1   engine can accept a byte (registered)
//   uart_tx        out  1   serial line, idle high (registered)
//   tx_busy        out  1   frame in progress
//   tx_done        out  1   one-cycle pulse when the stop period ends
//   tx_byte_count  out  16  frames completed, wraps at 0xFFFF
//   cts_n          in   1   clear-to-send, active low (UART_TX_CTS_EN only)
//
// Timing summary (D = effective bit period, S = stop length in cycles):
//   The FSM moves to START on the accept edge. uart_tx is registered from the
//   FSM state, so the line trails the FSM by one cycle: the start bit falls on
//   the edge after the accept edge. The STOP->IDLE edge raises tx_done, bumps
//   the byte count and re-raises tx_ready, while the line still shows the last
//   stop cycle. A byte offered back-to-back is therefore accepted on the next
//   edge and its start bit follows the previous one by frame+1 cycles.
// -----------------------------------------------------------------------------
module uart_tx_engine #(
    parameter int unsigned CLK_DIV_MIN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] clk_div,
    input  logic        check_en,
    input  logic [1:0]  check_type,
    input  logic [1:0]  data_bit,
    input  logic [1:0]  stop_bit,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [15:0] tx_byte_count
`ifdef UART_TX_CTS_EN
    ,
    input  logic        cts_n
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [31:0] DIV_MIN = 32'(CLK_DIV_MIN);

    // FSM state and per-frame shadow copies of the configuration
    state_t      r_state;
    logic [32:0] r_baud;        // cycles left in the current bit, minus one
    logic [2:0]  r_bit_idx;     // data bit being sent
    logic [2:0]  r_last_bit;    // index of the final data bit (N-1)
    logic [7:0]  r_data;        // masked data byte
    logic [31:0] r_div;         // effective bit period D
    logic [1:0]  r_stop_sel;    // latched stop_bit field
    logic        r_par_en;
    logic        r_par_bit;     // parity bit precomputed at accept

    // Registered outputs
    logic        r_uart_tx;
    logic        r_tx_ready;
    logic        r_tx_busy;
    logic        r_tx_done;
    logic [15:0] r_tx_byte_count;

    // Combinational helpers
    logic [31:0] w_div_eff;
    logic [7:0]  w_data_mask;
    logic [7:0]  w_data_masked;
    logic        w_parity;
    logic [32:0] w_bit_m1;
    logic [32:0] w_stop_cycles;
    logic [32:0] w_stop_m1;
    logic        w_accept;
    logic        w_baud_zero;
    logic        w_cts_clear;

    // -------------------------------------------------------------------------
    // Clear-to-send synchroniser
    // -------------------------------------------------------------------------
`ifdef UART_TX_CTS_EN
    logic r_cts_meta;
    logic r_cts_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
        end else begin
            r_cts_meta <= cts_n;
            r_cts_sync <= r_cts_meta;
        end
    end

    // tx_ready is a register, so it is fed from the value r_cts_sync takes on
    // the same edge; that keeps tx_ready equal to IDLE & ~cts_n_sync.
    assign w_cts_clear = ~r_cts_meta;
`else
    assign w_cts_clear = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Accept-time decoding of the live configuration
    // -------------------------------------------------------------------------
    assign w_div_eff = (clk_div < DIV_MIN) ? DIV_MIN : clk_div;

    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no
        // path leaves it unassigned, which would infer a latch.
        w_data_mask = 8'hFF;
        case (data_bit)
            2'b00:   w_data_mask = 8'h1F;
            2'b01:   w_data_mask = 8'h3F;
            2'b10:   w_data_mask = 8'h7F;
            default: w_data_mask = 8'hFF;
        endcase
        w_data_masked = tx_data & w_data_mask;

        w_parity = 1'b0;
        case (check_type)
            2'b00:   w_parity = ^w_data_masked;
            2'b01:   w_parity = ~(^w_data_masked);
            2'b10:   w_parity = 1'b1;
            default: w_parity = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Bit and stop periods from the latched divider (33 bits: 2*D never wraps)
    // -------------------------------------------------------------------------
    assign w_bit_m1 = {1'b0, r_div} - 33'd1;

    always_comb begin
        w_stop_cycles = {1'b0, r_div};
        case (r_stop_sel)
            2'b01:   w_stop_cycles = {1'b0, r_div} + {2'b00, r_div[31:1]};
            2'b10:   w_stop_cycles = {r_div, 1'b0};
            default: w_stop_cycles = {1'b0, r_div};
        endcase
    end

    assign w_stop_m1   = w_stop_cycles - 33'd1;
    assign w_accept    = (r_state == S_IDLE) && tx_valid && r_tx_ready;
    assign w_baud_zero = (r_baud == 33'd0);

    // -------------------------------------------------------------------------
    // Frame FSM. uart_tx is assigned from the current state in every branch, so
    // the line level is one register stage behind the state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_baud          <= '0;
            r_bit_idx       <= '0;
            r_last_bit      <= '0;
            r_data          <= '0;
            r_div           <= '0;
            r_stop_sel      <= '0;
            r_par_en        <= 1'b0;
            r_par_bit       <= 1'b0;
            r_uart_tx       <= 1'b1;
            r_tx_ready      <= 1'b0;
            r_tx_busy       <= 1'b0;
            r_tx_done       <= 1'b0;
            r_tx_byte_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            r_tx_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_uart_tx <= 1'b1;
                    if (w_accept) begin
                        r_data     <= w_data_masked;
                        r_last_bit <= 3'd4 + {1'b0, data_bit};
                        r_div      <= w_div_eff;
                        r_stop_sel <= stop_bit;
                        r_par_en   <= check_en;
                        r_par_bit  <= w_parity;
                        r_baud     <= {1'b0, w_div_eff} - 33'd1;
                        r_tx_ready <= 1'b0;
                        r_tx_busy  <= 1'b1;
                        r_state    <= S_START;
                    end else begin
                        r_tx_ready <= w_cts_clear;
                    end
                end

                S_START: begin
                    r_uart_tx <= 1'b0;
                    if (w_baud_zero) begin
                        r_baud    <= w_bit_m1;
                        r_bit_idx <= 3'd0;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud - 33'd1;
                    end
                end

                S_DATA: begin
                    r_uart_tx <= r_data[r_bit_idx];
                    if (w_baud_zero) begin
                        if (r_bit_idx == r_last_bit) begin
                            if (r_par_en) begin
                                r_baud  <= w_bit_m1;
                                r_state <= S_PARITY;
                            end else begin
                                r_baud  <= w_stop_m1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_baud    <= w_bit_m1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - 33'd1;
                    end
                end

                S_PARITY: begin
                    r_uart_tx <= r_par_bit;
                    if (w_baud_zero) begin
                        r_baud  <= w_stop_m1;
                        r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud - 33'd1;
                    end
                end

                S_STOP: begin
                    r_uart_tx <= 1'b1;
                    if (w_baud_zero) begin
                        r_tx_done       <= 1'b1;
                        r_tx_byte_count <= r_tx_byte_count + 16'd1;
                        r_tx_busy       <= 1'b0;
                        r_tx_ready      <= w_cts_clear;
                        r_state         <= S_IDLE;
                    end else begin
                        r_baud <= r_baud - 33'd1;
                    end
                end

                default: begin
                    r_uart_tx <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign uart_tx       = r_uart_tx;
    assign tx_ready      = r_tx_ready;
    assign tx_busy       = r_tx_busy;
    assign tx_done       = r_tx_done;
    assign tx_byte_count = r_tx_byte_count;

endmodule

// File: tb/tb_uart_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_engine
//
// Directed and random frames for uart_tx_engine. A negedge logger records the
// line and status outputs per clock; each accepted frame is then compared to a
// bit-level waveform built from the frame rules (D-cycle bits, S-cycle stop).
// Cycle numbering: log index k is the value seen after posedge number k; a
// byte accepted on edge A shows its first start cycle at index A+1, and
// tx_done / tx_ready / count update at index A+frame_length.
// -----------------------------------------------------------------------------
module tb_uart_tx_engine;

    localparam int LOGN = 16384;

    logic        clk;
    logic        rst_n;
    logic [31:0] clk_div;
    logic        check_en;
    logic [1:0]  check_type;
    logic [1:0]  data_bit;
    logic [1:0]  stop_bit;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        uart_tx;
    logic        tx_busy;
    logic        tx_done;
    logic [15:0] tx_byte_count;
`ifdef UART_TX_CTS_EN
    logic        cts_n;
`endif

    uart_tx_engine #(.CLK_DIV_MIN(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_div       (clk_div),
        .check_en      (check_en),
        .check_type    (check_type),
        .data_bit      (data_bit),
        .stop_bit      (stop_bit),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .uart_tx       (uart_tx),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_byte_count (tx_byte_count)
`ifdef UART_TX_CTS_EN
        ,
        .cts_n         (cts_n)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter and per-cycle log of DUT outputs
    int          cyc = 0;
    logic        log_tx    [LOGN];
    logic        log_done  [LOGN];
    logic        log_busy  [LOGN];
    logic        log_ready [LOGN];
    logic [15:0] log_cnt   [LOGN];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_tx[cyc]    <= uart_tx;
            log_done[cyc]  <= tx_done;
            log_busy[cyc]  <= tx_busy;
            log_ready[cyc] <= tx_ready;
            log_cnt[cyc]   <= tx_byte_count;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count = 0;
    bit exp_q[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference waveform of one frame, one entry per clk cycle of line time.
    task automatic build_frame(input logic [7:0] d, input int div, input logic [1:0] db,
                               input logic ce, input logic [1:0] ct, input logic [1:0] sb);
        int dd;
        int n;
        int ones;
        int s;
        bit par;
        dd = (div < 2) ? 2 : div;
        n = 5 + int'(db);
        ones = 0;
        exp_q.delete();
        for (int c = 0; c < dd; c++) exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            if (d[i]) ones++;
            for (int c = 0; c < dd; c++) exp_q.push_back(d[i]);
        end
        if (ce) begin
            case (ct)
                2'b00:   par = (ones % 2) == 1;
                2'b01:   par = (ones % 2) == 0;
                2'b10:   par = 1'b1;
                default: par = 1'b0;
            endcase
            for (int c = 0; c < dd; c++) exp_q.push_back(par);
        end
        if (sb == 2'b01)      s = dd + dd / 2;
        else if (sb == 2'b10) s = 2 * dd;
        else                  s = dd;
        for (int c = 0; c < s; c++) exp_q.push_back(1'b1);
    endtask

    // Offer a byte; returns the edge number on which it is accepted.
    task automatic send(input logic [7:0] d, input int div, input logic [1:0] db,
                        input logic ce, input logic [1:0] ct, input logic [1:0] sb,
                        input bit hold, output int acc);
        int waited;
        @(negedge clk);
        clk_div    = 32'(div);
        data_bit   = db;
        check_en   = ce;
        check_type = ct;
        stop_bit   = sb;
        tx_data    = d;
        tx_valid   = 1'b1;
        waited = 0;
        while (tx_ready !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("accept within budget", 64'(waited < 2000), 64'd1);
        acc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Compare the logged frame starting at accept edge acc with the model.
    task automatic check_frame(input string tag, input int acc, input logic [7:0] d,
                               input int div, input logic [1:0] db, input logic ce,
                               input logic [1:0] ct, input logic [1:0] sb,
                               input int cnt, output int dpos);
        int f;
        int mism;
        int first;
        int bad;
        build_frame(d, div, db, ce, ct, sb);
        f = exp_q.size();
        while (cyc < acc + f + 3) @(negedge clk);
        mism = 0;
        first = -1;
        for (int i = 0; i < f; i++) begin
            if (log_tx[acc + 1 + i] !== exp_q[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        check({tag, " line mismatching cycles"}, 64'(mism), 64'd0);
        if (first >= 0)
            $display("  %s first differing line cycle %0d", tag, first);
        dpos = -1;
        for (int k = acc + 1; k <= acc + f + 1; k++)
            if (log_done[k] === 1'b1 && dpos < 0) dpos = k - acc;
        check({tag, " tx_done offset"}, 64'(dpos), 64'(f));
        check({tag, " tx_done width"}, 64'(log_done[acc + f + 1]), 64'd0);
        bad = 0;
        for (int k = acc + 1; k < acc + f; k++)
            if (log_busy[k] !== 1'b1 || log_ready[k] !== 1'b0) bad++;
        if (log_busy[acc + f] !== 1'b0 || log_ready[acc + f] !== 1'b1) bad++;
        check({tag, " busy/ready cycles wrong"}, 64'(bad), 64'd0);
        check({tag, " byte count"}, 64'(log_cnt[acc + f]), 64'(cnt));
    endtask

    initial begin
        int acc;
        int acc2;
        int acc3;
        int dpos;
        int k;
        logic [9:0] seq;
        logic [9:0] obs10;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        logic [7:0] rd;
        int rdiv;
        logic [1:0] rdb;
        logic [1:0] rct;
        logic [1:0] rsb;
        logic rce;

        rst_n      = 1'b0;
        clk_div    = 32'd4;
        check_en   = 1'b0;
        check_type = 2'b00;
        data_bit   = 2'b11;
        stop_bit   = 2'b00;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
`ifdef UART_TX_CTS_EN
        cts_n      = 1'b0;
`endif

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("reset uart_tx", 64'(uart_tx), 64'd1);
        check("reset tx_ready", 64'(tx_ready), 64'd0);
        check("reset tx_busy", 64'(tx_busy), 64'd0);
        check("reset tx_done", 64'(tx_done), 64'd0);
        check("reset tx_byte_count", 64'(tx_byte_count), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle tx_ready", 64'(tx_ready), 64'd1);

        // ---- 1: 8N1 0xA5 at clk_div=4 ----
        send(8'hA5, 4, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, acc);
        exp_count++;
        check_frame("t1 8N1", acc, 8'hA5, 4, 2'b11, 1'b0, 2'b00, 2'b00, exp_count, dpos);
        check("t1 done 40 after accept", 64'(dpos), 64'd40);
        seq = 10'b1101001010;
        for (int i = 0; i < 10; i++) obs10[i] = log_tx[acc + 1 + 4 * i + 2];
        check("t1 bit sequence", 64'(obs10), 64'(seq));

        // ---- 2: 7 data bits + parity at clk_div=8; tx_valid/config churn mid-frame ----
        send(8'h35, 8, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0, acc);
        exp_count++;
        while (cyc < acc + 76) begin
            tx_valid   = 1'b1;
            tx_data    = 8'($urandom);
            check_type = 2'($urandom);
            data_bit   = 2'($urandom);
            check_en   = 1'($urandom);
            clk_div    = 32'($urandom_range(2, 20));
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check_frame("t2 even", acc, 8'h35, 8, 2'b10, 1'b1, 2'b00, 2'b00, exp_count, dpos);
        check("t2 even parity bit", 64'(log_tx[acc + 1 + 64 + 4]), 64'd0);

        send(8'hB5, 8, 2'b10, 1'b1, 2'b01, 2'b00, 1'b0, acc);
        exp_count++;
        check_frame("t2 odd", acc, 8'hB5, 8, 2'b10, 1'b1, 2'b01, 2'b00, exp_count, dpos);
        check("t2 odd parity bit (bit7 ignored)", 64'(log_tx[acc + 1 + 64 + 4]), 64'd1);

        send(8'h35, 8, 2'b10, 1'b1, 2'b10, 2'b00, 1'b0, acc);
        exp_count++;
        check_frame("t2 mark", acc, 8'h35, 8, 2'b10, 1'b1, 2'b10, 2'b00, exp_count, dpos);
        check("t2 mark parity bit", 64'(log_tx[acc + 1 + 64 + 4]), 64'd1);

        send(8'hB5, 8, 2'b10, 1'b1, 2'b11, 2'b00, 1'b0, acc);
        exp_count++;
        check_frame("t2 space", acc, 8'hB5, 8, 2'b10, 1'b1, 2'b11, 2'b00, exp_count, dpos);
        check("t2 space parity bit", 64'(log_tx[acc + 1 + 64 + 4]), 64'd0);

        // ---- 3: stop lengths and clk_div floor ----
        send(8'h5A, 10, 2'b11, 1'b0, 2'b00, 2'b01, 1'b0, acc);
        exp_count++;
        check_frame("t3 1.5 stop", acc, 8'h5A, 10, 2'b11, 1'b0, 2'b00, 2'b01, exp_count, dpos);
        check("t3 1.5 stop frame length", 64'(dpos), 64'd105);

        send(8'hC3, 10, 2'b11, 1'b0, 2'b00, 2'b10, 1'b0, acc);
        exp_count++;
        check_frame("t3 2 stop", acc, 8'hC3, 10, 2'b11, 1'b0, 2'b00, 2'b10, exp_count, dpos);
        check("t3 2 stop frame length", 64'(dpos), 64'd110);

        send(8'h81, 1, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, acc);
        exp_count++;
        check_frame("t3 clk_div=1", acc, 8'h81, 1, 2'b11, 1'b0, 2'b00, 2'b00, exp_count, dpos);
        check("t3 clk_div=1 frame length", 64'(dpos), 64'd20);

        // ---- 4: back-to-back with clk_div changed during frame 1 ----
        b1 = 8'h3C;
        b2 = 8'hE7;
        b3 = 8'h19;
        send(b1, 4, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, acc);
        tx_data = b2;
        while (cyc < acc + 10) @(negedge clk);
        clk_div = 32'd8;
        k = 0;
        while (tx_ready !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
        check("t4 second accept within budget", 64'(k < 2000), 64'd1);
        @(posedge clk);
        @(negedge clk);
        tx_data = b3;
        k = 0;
        while (tx_ready !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
        check("t4 third accept within budget", 64'(k < 2000), 64'd1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        acc2 = acc + 41;
        acc3 = acc2 + 81;
        check_frame("t4 frame1", acc, b1, 4, 2'b11, 1'b0, 2'b00, 2'b00, exp_count + 1, dpos);
        check_frame("t4 frame2", acc2, b2, 8, 2'b11, 1'b0, 2'b00, 2'b00, exp_count + 2, dpos);
        check_frame("t4 frame3", acc3, b3, 8, 2'b11, 1'b0, 2'b00, 2'b00, exp_count + 3, dpos);
        exp_count += 3;
        k = -1;
        for (int i = acc + 38; i < acc + 60; i++)
            if (k < 0 && log_tx[i] === 1'b0) k = i;
        check("t4 start-to-start spacing", 64'(k - (acc + 1)), 64'd41);

        // ---- 5: reset during data bit 3 ----
        send(8'hA5, 4, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, acc);
        while (cyc < acc + 17) @(negedge clk);
        check("t5 line in data bit 3", 64'(uart_tx), 64'd0);
        rst_n = 1'b0;
        #1;
        check("t5 reset uart_tx", 64'(uart_tx), 64'd1);
        check("t5 reset tx_busy", 64'(tx_busy), 64'd0);
        check("t5 reset tx_byte_count", 64'(tx_byte_count), 64'd0);
        check("t5 reset tx_ready", 64'(tx_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        repeat (4) @(negedge clk);
        send(8'h96, 4, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, acc);
        exp_count++;
        check_frame("t5 after reset", acc, 8'h96, 4, 2'b11, 1'b0, 2'b00, 2'b00, exp_count, dpos);

        // ---- random frames ----
        for (int r = 0; r < 16; r++) begin
            rd   = 8'($urandom);
            rdiv = int'($urandom_range(0, 6));
            rdb  = 2'($urandom);
            rce  = 1'($urandom);
            rct  = 2'($urandom);
            rsb  = 2'($urandom);
            send(rd, rdiv, rdb, rce, rct, rsb, 1'b0, acc);
            exp_count++;
            check_frame("rand", acc, rd, rdiv, rdb, rce, rct, rsb, exp_count, dpos);
        end

`ifdef UART_TX_CTS_EN
        // ---- 6: clear-to-send gating ----
        @(negedge clk);
        cts_n = 1'b1;
        repeat (4) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        acc = cyc;
        repeat (12) @(negedge clk);
        k = 0;
        for (int i = acc; i < acc + 10; i++) if (log_tx[i] !== 1'b1) k++;
        check("t6 no start while cts_n=1", 64'(k), 64'd0);
        check("t6 tx_ready low while cts_n=1", 64'(tx_ready), 64'd0);
        tx_valid = 1'b0;
        cts_n = 1'b0;
        send(8'h55, 4, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, acc);
        exp_count++;
        while (cyc < acc + 20) @(negedge clk);
        cts_n = 1'b1;
        while (cyc < acc + 30) @(negedge clk);
        cts_n = 1'b0;
        check_frame("t6 cts mid-frame", acc, 8'h55, 4, 2'b11, 1'b0, 2'b00, 2'b00, exp_count, dpos);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
